// File: rtl/chan_cnt_pkg.sv
// Shared types and helpers for the channelised up/down counter bank.
package chan_cnt_pkg;

  // Per-cycle operation applied to the bank (and, gated by sel, to each cell).
  typedef enum logic [2:0] {
    OP_IDLE = 3'd0,
    OP_LOAD = 3'd1,
    OP_UP   = 3'd2,
    OP_DOWN = 3'd3,
    OP_ERR  = 3'd4
  } cnt_op_t;

  // Overflow behaviour selector for the SAT parameter.
  localparam int CNT_MODE_WRAP = 0;
  localparam int CNT_MODE_SAT  = 1;

  // True when exactly one bit of v is set. Callers zero-extend narrower
  // selects to 64 bits, so the bank supports up to 64 channels.
  function automatic logic is_onehot(input logic [63:0] v);
    return (v != 64'd0) && ((v & (v - 64'd1)) == 64'd0);
  endfunction

endpackage

// File: rtl/updown_cnt_cell.sv
// One counter channel: holds its value and computes the post-update value
// and the wrap/clamp indication for the op presented this cycle.
module updown_cnt_cell
  import chan_cnt_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4,
  parameter int SAT    = CNT_MODE_WRAP
) (
  input  logic              clk,
  input  logic              reset,
  input  cnt_op_t           op,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  value,
  output logic [WIDTH-1:0]  value_next,
  output logic              wrapped
);

  logic [WIDTH-1:0] r_value;
  logic [WIDTH:0]   w_step_ext;
  logic [WIDTH:0]   w_sum;

  // The extra top bit of the sum is the carry (up) or borrow (down).
  assign w_step_ext = {{(WIDTH + 1 - STEP_W){1'b0}}, step};

  // Next value and wrap flag; any op other than LOAD/UP/DOWN holds.
  always_comb begin
    value_next = r_value;
    wrapped    = 1'b0;
    w_sum      = {1'b0, r_value};
    case (op)
      OP_LOAD: begin
        value_next = load_val;
      end
      OP_UP: begin
        w_sum = {1'b0, r_value} + w_step_ext;
        if (w_sum[WIDTH]) begin
          wrapped    = 1'b1;
          value_next = (SAT == CNT_MODE_SAT) ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
        end else begin
          value_next = w_sum[WIDTH-1:0];
        end
      end
      OP_DOWN: begin
        w_sum = {1'b0, r_value} - w_step_ext;
        if (w_sum[WIDTH]) begin
          wrapped    = 1'b1;
          value_next = (SAT == CNT_MODE_SAT) ? {WIDTH{1'b0}} : w_sum[WIDTH-1:0];
        end else begin
          value_next = w_sum[WIDTH-1:0];
        end
      end
      default: begin
      end
    endcase
  end

  // Channel register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_value <= '0;
    end else begin
      r_value <= value_next;
    end
  end

  assign value = r_value;

endmodule

// File: rtl/chan_updown_counter.sv
// Bank of NCH up/down counters addressed by a one-hot select, with a
// registered readback of the selected channel, boundary flags, a wrap
// pulse and a sticky illegal-select error.
module chan_updown_counter
  import chan_cnt_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NCH    = 4,
  parameter int STEP_W = 4,
  parameter int SAT    = CNT_MODE_WRAP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [NCH-1:0]    sel,
  input  logic              reverse,
  input  logic [STEP_W-1:0] step,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              clr_err,
  output logic [WIDTH-1:0]  count,
  output logic              valid,
  output logic              at_max,
  output logic              at_min,
  output logic              wrapped,
  output logic              sel_err
);

  logic             w_sel_legal;
  logic             w_sel_multi;
  cnt_op_t          w_op;

  logic [WIDTH-1:0] w_chan_value [NCH];
  logic [WIDTH-1:0] w_chan_next  [NCH];
  logic [NCH-1:0]   w_chan_wrap;

  logic [WIDTH-1:0] w_rd_value;
  logic [WIDTH-1:0] w_rd_next;
  logic             w_rd_wrap;

  logic [WIDTH-1:0] w_count_next;
  logic             w_valid_next;
  logic             w_wrapped_next;

  logic [WIDTH-1:0] r_count;
  logic             r_valid;
  logic             r_at_max;
  logic             r_at_min;
  logic             r_wrapped;
  logic             r_sel_err;

  // Op decode in priority order: ERR, IDLE, LOAD, UP, DOWN.
  always_comb begin
    w_sel_legal = is_onehot(64'(sel));
    w_sel_multi = (sel != '0) && !w_sel_legal;
    w_op        = OP_IDLE;
    if (en && w_sel_multi) begin
      w_op = OP_ERR;
    end else if (!en || (sel == '0)) begin
      w_op = OP_IDLE;
    end else if (load) begin
      w_op = OP_LOAD;
    end else if (!reverse) begin
      w_op = OP_UP;
    end else begin
      w_op = OP_DOWN;
    end
  end

  // One cell per channel; only the selected cell sees a real op, and an ERR
  // cycle never reaches any cell so the whole bank holds.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    cnt_op_t w_cell_op;

    assign w_cell_op = (sel[gi] && (w_op != OP_ERR)) ? w_op : OP_IDLE;

    updown_cnt_cell #(
      .WIDTH  (WIDTH),
      .STEP_W (STEP_W),
      .SAT    (SAT)
    ) u_cell (
      .clk        (clk),
      .reset      (reset),
      .op         (w_cell_op),
      .step       (step),
      .load_val   (load_val),
      .value      (w_chan_value[gi]),
      .value_next (w_chan_next[gi]),
      .wrapped    (w_chan_wrap[gi])
    );
  end

  // AND-OR readback mux; only meaningful when sel is one-hot.
  always_comb begin
    w_rd_value = '0;
    w_rd_next  = '0;
    w_rd_wrap  = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (sel[i]) begin
        w_rd_value = w_rd_value | w_chan_value[i];
        w_rd_next  = w_rd_next  | w_chan_next[i];
        w_rd_wrap  = w_rd_wrap  | w_chan_wrap[i];
      end
    end
  end

  // Readback selection: a legal select reports the post-update value (the
  // stored value when nothing updates); any other select holds count.
  always_comb begin
    w_count_next   = r_count;
    w_valid_next   = 1'b0;
    w_wrapped_next = 1'b0;
    if (w_sel_legal) begin
      w_count_next   = (w_op == OP_IDLE) ? w_rd_value : w_rd_next;
      w_valid_next   = 1'b1;
      w_wrapped_next = w_rd_wrap;
    end
  end

  // Output registers; boundary flags are derived from the next count so they
  // line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count   <= '0;
      r_valid   <= 1'b0;
      r_at_max  <= 1'b0;
      r_at_min  <= 1'b1;
      r_wrapped <= 1'b0;
    end else begin
      r_count   <= w_count_next;
      r_valid   <= w_valid_next;
      r_at_max  <= (w_count_next == {WIDTH{1'b1}});
      r_at_min  <= (w_count_next == {WIDTH{1'b0}});
      r_wrapped <= w_wrapped_next;
    end
  end

  // Sticky select error; a new error beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel_err <= 1'b0;
    end else if (w_op == OP_ERR) begin
      r_sel_err <= 1'b1;
    end else if (clr_err) begin
      r_sel_err <= 1'b0;
    end
  end

  assign count   = r_count;
  assign valid   = r_valid;
  assign at_max  = r_at_max;
  assign at_min  = r_at_min;
  assign wrapped = r_wrapped;
  assign sel_err = r_sel_err;

endmodule

// File: tb/tb_chan_updown_counter.sv
// Directed and randomized checks of the counter bank, run on a wrap-mode and
// a saturate-mode instance driven by the same inputs.
module tb_chan_updown_counter;

  logic       clk = 1'b0;
  logic       reset, en, reverse, load, clr_err;
  logic [3:0] sel;
  logic [3:0] step;
  logic [7:0] load_val;

  logic [7:0] count_w, count_s;
  logic       valid_w, valid_s, at_max_w, at_max_s, at_min_w, at_min_s;
  logic       wrapped_w, wrapped_s, sel_err_w, sel_err_s;

  always #5 clk = ~clk;

  chan_updown_counter #(.WIDTH(8), .NCH(4), .STEP_W(4), .SAT(0)) u_wrap (
    .clk(clk), .reset(reset), .en(en), .sel(sel), .reverse(reverse), .step(step),
    .load(load), .load_val(load_val), .clr_err(clr_err),
    .count(count_w), .valid(valid_w), .at_max(at_max_w), .at_min(at_min_w),
    .wrapped(wrapped_w), .sel_err(sel_err_w)
  );

  chan_updown_counter #(.WIDTH(8), .NCH(4), .STEP_W(4), .SAT(1)) u_sat (
    .clk(clk), .reset(reset), .en(en), .sel(sel), .reverse(reverse), .step(step),
    .load(load), .load_val(load_val), .clr_err(clr_err),
    .count(count_s), .valid(valid_s), .at_max(at_max_s), .at_min(at_min_s),
    .wrapped(wrapped_s), .sel_err(sel_err_s)
  );

  // Reference state: index 0 = wrap instance, 1 = saturate instance.
  int m_chan  [2][4];
  int m_count [2];
  bit m_valid [2];
  bit m_wrap  [2];
  bit m_err   [2];

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one clock's worth of inputs to the reference using plain integers.
  task automatic model_step();
    int n, idx, v;
    n   = $countones(sel);
    idx = 0;
    for (int b = 0; b < 4; b++) if (sel[b]) idx = b;
    for (int m = 0; m < 2; m++) begin
      if (reset) begin
        for (int c = 0; c < 4; c++) m_chan[m][c] = 0;
        m_count[m] = 0; m_valid[m] = 0; m_wrap[m] = 0; m_err[m] = 0;
      end else if (en && n > 1) begin
        m_err[m] = 1; m_valid[m] = 0; m_wrap[m] = 0;
      end else begin
        if (clr_err) m_err[m] = 0;
        m_wrap[m]  = 0;
        m_valid[m] = 0;
        if (n == 1) begin
          if (en) begin
            if (load) begin
              m_chan[m][idx] = int'(load_val);
            end else begin
              v = reverse ? m_chan[m][idx] - int'(step) : m_chan[m][idx] + int'(step);
              if (v > 255) begin
                m_wrap[m] = 1;
                v = (m == 1) ? 255 : v - 256;
              end else if (v < 0) begin
                m_wrap[m] = 1;
                v = (m == 1) ? 0 : v + 256;
              end
              m_chan[m][idx] = v;
            end
          end
          m_count[m] = m_chan[m][idx];
          m_valid[m] = 1;
        end
      end
    end
  endtask

  task automatic check_all(input string pfx);
    check({pfx, ".w.count"},   32'(count_w),   32'(m_count[0]));
    check({pfx, ".w.valid"},   32'(valid_w),   32'(m_valid[0]));
    check({pfx, ".w.at_max"},  32'(at_max_w),  32'(m_count[0] == 255));
    check({pfx, ".w.at_min"},  32'(at_min_w),  32'(m_count[0] == 0));
    check({pfx, ".w.wrapped"}, 32'(wrapped_w), 32'(m_wrap[0]));
    check({pfx, ".w.sel_err"}, 32'(sel_err_w), 32'(m_err[0]));
    check({pfx, ".s.count"},   32'(count_s),   32'(m_count[1]));
    check({pfx, ".s.valid"},   32'(valid_s),   32'(m_valid[1]));
    check({pfx, ".s.at_max"},  32'(at_max_s),  32'(m_count[1] == 255));
    check({pfx, ".s.at_min"},  32'(at_min_s),  32'(m_count[1] == 0));
    check({pfx, ".s.wrapped"}, 32'(wrapped_s), 32'(m_wrap[1]));
    check({pfx, ".s.sel_err"}, 32'(sel_err_s), 32'(m_err[1]));
  endtask

  // One clock: inputs are already stable, outputs are sampled 1 time unit later.
  task automatic cycle(input string pfx);
    @(posedge clk);
    model_step();
    #1;
    check_all(pfx);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; sel = 4'b0000; reverse = 1'b0; step = 4'd0;
    load = 1'b0; load_val = 8'h00; clr_err = 1'b0;
    #2;
    cycle("rst");
    check("rst.count", 32'(count_w), 32'h0);
    check("rst.at_min", 32'(at_min_w), 32'h1);
    reset = 1'b0;

    // 1. count up by one on channel 0, then read the untouched channels.
    sel = 4'b0001; en = 1'b1; step = 4'd1;
    for (int i = 1; i <= 3; i++) begin
      cycle("t1");
      check("t1.count", 32'(count_w), 32'(i));
      check("t1.valid", 32'(valid_w), 32'h1);
    end
    en = 1'b0;
    for (int c = 1; c < 4; c++) begin
      sel = 4'(1 << c);
      cycle("t1rd");
      check("t1rd.count", 32'(count_w), 32'h0);
    end

    // 2. wrap on overflow, single-cycle pulse.
    sel = 4'b0100; en = 1'b1; load = 1'b1; load_val = 8'hFE;
    cycle("t2ld");
    load = 1'b0; step = 4'd3;
    cycle("t2up");
    check("t2.count", 32'(count_w), 32'h01);
    check("t2.wrapped", 32'(wrapped_w), 32'h1);
    en = 1'b0;
    cycle("t2idle");
    check("t2.wrapped_off", 32'(wrapped_w), 32'h0);

    // 3. saturating clamps at both ends.
    en = 1'b1; load = 1'b1; load_val = 8'h02;
    cycle("t3ld");
    load = 1'b0; reverse = 1'b1; step = 4'd5;
    cycle("t3dn");
    check("t3.s.count", 32'(count_s), 32'h00);
    check("t3.s.at_min", 32'(at_min_s), 32'h1);
    check("t3.s.wrapped", 32'(wrapped_s), 32'h1);
    load = 1'b1; load_val = 8'hF5;
    cycle("t3ld2");
    load = 1'b0; reverse = 1'b0; step = 4'd15;
    cycle("t3up");
    check("t3.s.count_max", 32'(count_s), 32'hFF);
    check("t3.s.at_max", 32'(at_max_s), 32'h1);

    // 4. illegal select, clear, and set-beats-clear.
    sel = 4'b0110; en = 1'b1;
    cycle("t4err");
    check("t4.sel_err", 32'(sel_err_w), 32'h1);
    check("t4.valid", 32'(valid_w), 32'h0);
    sel = 4'b0000; en = 1'b0; clr_err = 1'b1;
    cycle("t4clr");
    check("t4.cleared", 32'(sel_err_w), 32'h0);
    sel = 4'b0110; en = 1'b1;
    cycle("t4both");
    check("t4.set_wins", 32'(sel_err_w), 32'h1);
    clr_err = 1'b0;

    // 5. load beats reverse/step; step=0 holds.
    sel = 4'b0010; load = 1'b1; reverse = 1'b1; step = 4'd7; load_val = 8'h40;
    cycle("t5ld");
    check("t5.count", 32'(count_w), 32'h40);
    load = 1'b0; step = 4'd0;
    cycle("t5hold");
    check("t5.hold", 32'(count_w), 32'h40);
    check("t5.nowrap", 32'(wrapped_w), 32'h0);

    // 6. reset in the middle of counting on channel 3.
    sel = 4'b1000; load = 1'b1; load_val = 8'h29; reverse = 1'b0;
    cycle("t6ld");
    load = 1'b0; step = 4'd1;
    cycle("t6up");
    check("t6.count", 32'(count_w), 32'h2A);
    reset = 1'b1;
    cycle("t6rst");
    check("t6.rst_count", 32'(count_w), 32'h0);
    check("t6.rst_valid", 32'(valid_w), 32'h0);
    check("t6.rst_sel_err", 32'(sel_err_w), 32'h0);
    reset = 1'b0; en = 1'b0;
    for (int c = 0; c < 4; c++) begin
      sel = 4'(1 << c);
      cycle("t6rd");
      check("t6rd.count", 32'(count_s), 32'h0);
    end

    // Randomized traffic against the reference.
    for (int k = 0; k < 400; k++) begin
      int r;
      r        = int'($urandom_range(0, 9));
      sel      = (r == 0) ? 4'b0000 : (r == 1) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
      en       = ($urandom_range(0, 3) != 0);
      reverse  = 1'($urandom);
      step     = 4'($urandom);
      load     = ($urandom_range(0, 5) == 0);
      load_val = 8'($urandom);
      clr_err  = ($urandom_range(0, 7) == 0);
      reset    = ($urandom_range(0, 49) == 0);
      cycle("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
